// File: rtl/smi_pkg.sv
// ---------------------------------------------------------------------------
// smi_pkg
// Shared definitions for the PHY management (MDIO Clause 22) bring-up
// controller: opcodes, register addresses, frame geometry, the controller
// state enum and a helper that assembles a complete 64-bit frame.
// ---------------------------------------------------------------------------
package smi_pkg;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;

    // BMSR link-status bit
    localparam int LINK_BIT = 2;

    localparam int FRAME_BITS     = 64;
    // First bit index that the PHY owns during a read (turnaround)
    localparam int RD_RELEASE_BIT = 46;
    // First bit index of the read data field
    localparam int RD_DATA_BIT    = 48;

    typedef enum logic [2:0] {
        WAIT_RST,
        PWRUP,
        WR_BMCR,
        RD_BMSR,
        GAP,
        DONE
    } smiState_e;

    // Preamble, ST, OP, PHYAD, REGAD, TA, DATA. For a read the TA and data
    // bits are never driven, so they are filled with idle ones.
    function automatic logic [63:0] buildFrame(input logic [1:0]  op,
                                               input logic [4:0]  phyad,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
        logic [1:0]  ta;
        logic [15:0] data;
        ta   = (op == OP_WR) ? 2'b10 : 2'b11;
        data = (op == OP_WR) ? wdata : 16'hFFFF;
        return {32'hFFFF_FFFF, 2'b01, op, phyad, regad, ta, data};
    endfunction

endpackage

// File: rtl/smi_if.sv
// ---------------------------------------------------------------------------
// smi_if
// MDIO pad bundle between the management controller (master) and the PHY
// side (slave).
//   mdc_o       : MDIO clock
//   mdio_o      : pad output value
//   mdio_out_en : pad output enable, 1 = drive
//   mdio_i      : pad input value
// ---------------------------------------------------------------------------
interface smi_if;
    logic mdc_o;
    logic mdio_o;
    logic mdio_out_en;
    logic mdio_i;

    modport master (
        output mdc_o,
        output mdio_o,
        output mdio_out_en,
        input  mdio_i
    );

    modport slave (
        input  mdc_o,
        input  mdio_o,
        input  mdio_out_en,
        output mdio_i
    );
endinterface

// File: rtl/smi_frame.sv
// ---------------------------------------------------------------------------
// smi_frame
// Serialises one 64-bit Clause 22 frame, two clk1m cycles per bit (low phase
// presents data, high phase holds it), and captures read data MSB first.
// Ports:
//   clk1m, rst   : clock, synchronous active-high reset
//   i_abort      : drop any frame in flight and idle the bus
//   i_start      : begin a frame (ignored while busy)
//   i_op, i_phyad, i_regad, i_wdata : frame fields
//   o_busy       : frame in progress
//   o_done       : one-cycle pulse in the cycle after the last high phase
//   o_rdata      : read data, valid with o_done of a read frame
//   bus          : MDIO pads (master side)
// ---------------------------------------------------------------------------
module smi_frame
    import smi_pkg::*;
(
    input  logic        clk1m,
    input  logic        rst,
    input  logic        i_abort,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [4:0]  i_phyad,
    input  logic [4:0]  i_regad,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rdata,
    smi_if.master       bus
);

    logic [63:0] w_frame;
    logic [63:0] r_shift;
    logic [5:0]  r_bitCnt;
    logic        r_highPhase;
    logic        r_busy;
    logic        r_done;
    logic        r_isRead;
    logic [15:0] r_rdata;
    logic        r_mdc;
    logic        r_mdio;
    logic        r_oe;

    assign w_frame = buildFrame(i_op, i_phyad, i_regad, i_wdata);

    // Bit sequencer. Bit 0 is presented on the start edge so the whole frame
    // spans exactly 128 cycles; r_shift holds the bits still to be sent.
    always_ff @(posedge clk1m) begin
        if (rst || i_abort) begin
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_highPhase <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_isRead    <= 1'b0;
            r_rdata     <= '0;
            r_mdc       <= 1'b0;
            r_mdio      <= 1'b1;
            r_oe        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_busy      <= 1'b1;
                    r_isRead    <= (i_op == OP_RD);
                    r_bitCnt    <= '0;
                    r_highPhase <= 1'b0;
                    r_rdata     <= '0;
                    r_mdc       <= 1'b0;
                    r_mdio      <= w_frame[63];
                    r_shift     <= {w_frame[62:0], 1'b1};
                    r_oe        <= 1'b1;
                end
            end else if (!r_highPhase) begin
                r_mdc       <= 1'b1;
                r_highPhase <= 1'b1;
            end else begin
                r_mdc       <= 1'b0;
                r_highPhase <= 1'b0;
                // The PHY drives data after mdc rises; sample as mdc falls
                if (r_isRead && r_bitCnt >= 6'(RD_DATA_BIT)) begin
                    r_rdata <= {r_rdata[14:0], bus.mdio_i};
                end
                if (r_bitCnt == 6'(FRAME_BITS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_mdio <= 1'b1;
                    r_oe   <= 1'b0;
                end else begin
                    r_bitCnt <= r_bitCnt + 6'd1;
                    r_mdio   <= r_shift[63];
                    r_shift  <= {r_shift[62:0], 1'b1};
                    // Release the pad from the turnaround onward on reads
                    r_oe     <= !(r_isRead && r_bitCnt >= 6'(RD_RELEASE_BIT - 1));
                end
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_rdata         = r_rdata;
    assign bus.mdc_o       = r_mdc;
    assign bus.mdio_o      = r_mdio;
    assign bus.mdio_out_en = r_oe;

endmodule

// File: rtl/smi_init.sv
// ---------------------------------------------------------------------------
// smi_init
// PHY management bring-up: waits for the PHY to leave reset, waits a
// power-up delay, writes BMCR, optionally polls BMSR until link is up, then
// raises the sticky 'ready' that gates packet transmission.
// Optional feature macro: SMI_LINK_POLL_EN (BMSR link polling).
// Ports:
//   clk1m  : 1 MHz clock
//   rst    : synchronous active-high reset
//   phyrst : high while the PHY is held in reset
//   ready  : PHY configured (and link up when polling), sticky until rst
//   bus    : MDIO pads (master side)
// Minimum useful POLL_GAP_CYCLES is 2; PWRUP_CYCLES must be at least 1.
// ---------------------------------------------------------------------------
module smi_init
    import smi_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR        = 5'd1,
    parameter logic [15:0] BMCR_VALUE      = 16'h2100,
    parameter int          PWRUP_CYCLES    = 10000,
    parameter int          POLL_GAP_CYCLES = 1000
) (
    input  logic  clk1m,
    input  logic  rst,
    input  logic  phyrst,
    output logic  ready,
    smi_if.master bus
);

    localparam int CNT_MAX = (PWRUP_CYCLES > POLL_GAP_CYCLES) ? PWRUP_CYCLES : POLL_GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
`ifdef SMI_LINK_POLL_EN
    // The frame's done cycle and the GAP entry cycle are already idle, so the
    // gap counter stops two short to give exactly POLL_GAP_CYCLES idle cycles.
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((POLL_GAP_CYCLES >= 2) ? POLL_GAP_CYCLES - 2 : 0);
`endif

    smiState_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;

    logic        w_start;
    logic        w_abort;
    logic        w_isWrite;
    logic [1:0]  w_op;
    logic [4:0]  w_regad;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_rdata;
    logic        w_unused;

    // Frame launch happens on the same edge as the state transition, so the
    // start strobe is decoded from the current state and counter.
    always_comb begin
        w_start   = 1'b0;
        w_isWrite = (r_state == PWRUP);
        if (!phyrst) begin
            case (r_state)
                PWRUP:   w_start = (r_cnt == PWRUP_LAST);
`ifdef SMI_LINK_POLL_EN
                WR_BMCR: w_start = w_done;
                GAP:     w_start = (r_cnt >= GAP_LAST);
`endif
                default: w_start = 1'b0;
            endcase
        end
    end

    assign w_op     = w_isWrite ? OP_WR : OP_RD;
    assign w_regad  = w_isWrite ? REG_BMCR : REG_BMSR;
    assign w_abort  = phyrst && (r_state != DONE);
    assign w_unused = ^{w_busy, w_rdata};

    smi_frame u_frame (
        .clk1m   (clk1m),
        .rst     (rst),
        .i_abort (w_abort),
        .i_start (w_start),
        .i_op    (w_op),
        .i_phyad (PHY_ADDR),
        .i_regad (w_regad),
        .i_wdata (BMCR_VALUE),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_rdata (w_rdata),
        .bus     (bus)
    );

    // Bring-up sequencer. A PHY reset before DONE restarts from WAIT_RST;
    // once DONE is reached only rst leaves it.
    always_ff @(posedge clk1m) begin
        if (rst) begin
            r_state <= WAIT_RST;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                WAIT_RST: begin
                    if (!phyrst) begin
                        r_cnt   <= '0;
                        r_state <= PWRUP;
                    end
                end
                PWRUP: begin
                    if (phyrst) begin
                        r_state <= WAIT_RST;
                    end else if (r_cnt == PWRUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= WR_BMCR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR_BMCR: begin
                    if (phyrst) begin
                        r_state <= WAIT_RST;
                    end else if (w_done) begin
`ifdef SMI_LINK_POLL_EN
                        r_state <= RD_BMSR;
`else
                        r_state <= DONE;
                        r_ready <= 1'b1;
`endif
                    end
                end
`ifdef SMI_LINK_POLL_EN
                RD_BMSR: begin
                    if (phyrst) begin
                        r_state <= WAIT_RST;
                    end else if (w_done) begin
                        if (w_rdata[LINK_BIT]) begin
                            r_state <= DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (phyrst) begin
                        r_state <= WAIT_RST;
                    end else if (r_cnt >= GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RD_BMSR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= WAIT_RST;
                end
            endcase
        end
    end

    assign ready = r_ready;

endmodule

// File: tb/tb_smi_init.sv
// ---------------------------------------------------------------------------
// tb_smi_init
// Self-checking bench for smi_init. Stimulus pushes expected frames into a
// queue; a monitor decodes frames on mdc_o rising edges, plays the PHY for
// read data, and compares each finished frame and the ready rise against the
// queue. Follows SMI_LINK_POLL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_smi_init;

    localparam int PWRUP   = 100;
    localparam int GAP_CYC = 20;

    localparam logic [63:0] WR_FRAME = 64'hFFFF_FFFF_5082_2100;
    localparam logic [63:0] WR_OE    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] RD_FRAME = 64'hFFFF_FFFF_6087_FFFF;
    localparam logic [63:0] RD_OE    = 64'hFFFF_FFFF_FFFC_0000;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] oe;
        int          startRef;   // 0: relative to phyrst fall, 1: to previous frame end
        int          delta;
        bit          readyAfter;
    } frameExp_t;

    logic clk1m  = 1'b0;
    logic rst    = 1'b1;
    logic phyrst = 1'b1;
    logic ready;

    smi_if bus ();

    smi_init #(
        .PHY_ADDR        (5'd1),
        .BMCR_VALUE      (16'h2100),
        .PWRUP_CYCLES    (PWRUP),
        .POLL_GAP_CYCLES (GAP_CYC)
    ) dut (
        .clk1m  (clk1m),
        .rst    (rst),
        .phyrst (phyrst),
        .ready  (ready),
        .bus    (bus)
    );

    always #5 clk1m = ~clk1m;

    frameExp_t   expQ[$];
    logic [15:0] phyQ[$];
    frameExp_t   curExp;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;
    int fallCyc     = 0;

    int          bitIdx       = 0;
    int          firstRise    = 0;
    int          lastFrameEnd = 0;
    int          frameCount   = 0;
    int          pendingReady = -1;
    int          expStart     = 0;
    logic [63:0] gotBits      = '0;
    logic [63:0] gotOe        = '0;
    logic        prevMdc      = 1'b0;
    logic        prevReady    = 1'b0;
    logic        isRead       = 1'b0;
    logic [15:0] curResp      = 16'hFFFF;

    // Cycle counter, one per rising edge
    always @(posedge clk1m) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic phyrstVal, input int cycles);
        rst    = rstVal;
        phyrst = phyrstVal;
        repeat (cycles) begin
            @(posedge clk1m);
            #1;
        end
    endtask

    // Monitor and PHY model, sampled mid-cycle on the falling clk1m edge
    always @(negedge clk1m) begin
        if (rst) begin
            bitIdx       = 0;
            prevMdc      = 1'b0;
            prevReady    = 1'b0;
            pendingReady = -1;
            frameCount   = 0;
            isRead       = 1'b0;
            bus.mdio_i   = 1'b1;
        end else begin
            if (bitIdx == 0 && !bus.mdc_o) bus.mdio_i = 1'b1;
            if (bus.mdc_o && !prevMdc) begin
                if (bitIdx == 0) firstRise = cyc;
                gotBits = {gotBits[62:0], bus.mdio_o};
                gotOe   = {gotOe[62:0], bus.mdio_out_en};
                if (bitIdx == 35) isRead = (gotBits[1:0] == 2'b10);
                if (bitIdx == 48 && isRead) begin
                    curResp = (phyQ.size() > 0) ? phyQ.pop_front() : 16'h0000;
                end
                if (bitIdx >= 48 && isRead) bus.mdio_i = curResp[15 - (bitIdx - 48)];
                bitIdx++;
                if (bitIdx == 64) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_frame", 64'd1, 64'd0);
                    end else begin
                        curExp   = expQ.pop_front();
                        expStart = (curExp.startRef == 0) ? fallCyc + curExp.delta
                                                          : lastFrameEnd + curExp.delta;
                        checkOutput("frame_bits", gotBits & curExp.oe, curExp.bits & curExp.oe);
                        checkOutput("frame_oe", gotOe, curExp.oe);
                        checkOutput("frame_start_cycle", 64'(firstRise), 64'(expStart));
                        if (curExp.readyAfter) pendingReady = cyc + 2;
                    end
                    lastFrameEnd = cyc;
                    frameCount++;
                    bitIdx = 0;
                    isRead = 1'b0;
                end
            end
            if (ready && !prevReady) begin
                checkOutput("ready_rise_cycle", 64'(cyc), 64'(pendingReady));
            end
            prevMdc   = bus.mdc_o;
            prevReady = ready;
        end
    end

    initial begin
        int  expFrames;
        bit  timedOut;

        // Reset state
        applyStimulus(1'b1, 1'b1, 5);
        @(negedge clk1m);
        checkOutput("reset_ready", 64'(ready), 64'd0);
        checkOutput("reset_mdc", 64'(bus.mdc_o), 64'd0);
        checkOutput("reset_mdio", 64'(bus.mdio_o), 64'd1);
        checkOutput("reset_oe", 64'(bus.mdio_out_en), 64'd0);
        @(posedge clk1m);
        #1;

        // PHY held in reset: bus stays idle
        applyStimulus(1'b0, 1'b1, 20);
        @(negedge clk1m);
        checkOutput("phyrst_ready", 64'(ready), 64'd0);
        checkOutput("phyrst_oe", 64'(bus.mdio_out_en), 64'd0);
        @(posedge clk1m);
        #1;

        // Release the PHY, then abort the write frame at bit 20
        fallCyc = cyc;
        expQ.push_back('{WR_FRAME, WR_OE, 0, PWRUP + 2, 1'b0});
        phyrst   = 1'b0;
        timedOut = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk1m);
            #1;
            if (bitIdx >= 20) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("abort_wait_timeout", 64'(timedOut), 64'd0);
        rst = 1'b1;
        @(posedge clk1m);
        @(negedge clk1m);
        checkOutput("abort_ready", 64'(ready), 64'd0);
        checkOutput("abort_mdc", 64'(bus.mdc_o), 64'd0);
        checkOutput("abort_mdio", 64'(bus.mdio_o), 64'd1);
        checkOutput("abort_oe", 64'(bus.mdio_out_en), 64'd0);
        expQ.delete();
        @(posedge clk1m);
        #1;

        // Restart from WAIT_RST with phyrst already low
        rst     = 1'b0;
        fallCyc = cyc;
`ifdef SMI_LINK_POLL_EN
        expQ.push_back('{WR_FRAME, WR_OE, 0, PWRUP + 2, 1'b0});
        expQ.push_back('{RD_FRAME, RD_OE, 1, 3, 1'b0});
        expQ.push_back('{RD_FRAME, RD_OE, 1, GAP_CYC + 2, 1'b1});
        phyQ.push_back(16'h7809);
        phyQ.push_back(16'h782D);
        expFrames = 3;
`else
        expQ.push_back('{WR_FRAME, WR_OE, 0, PWRUP + 2, 1'b1});
        expFrames = 1;
`endif

        timedOut = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk1m);
            #1;
            if (ready) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("ready_wait_timeout", 64'(timedOut), 64'd0);

        // Terminal state: no further frames, bus idle, ready sticky
        repeat (300) @(posedge clk1m);
        @(negedge clk1m);
        checkOutput("pending_frames", 64'(expQ.size()), 64'd0);
        checkOutput("frame_count", 64'(frameCount), 64'(expFrames));
        checkOutput("phy_responses_left", 64'(phyQ.size()), 64'd0);
        checkOutput("done_ready", 64'(ready), 64'd1);
        checkOutput("done_mdc", 64'(bus.mdc_o), 64'd0);
        checkOutput("done_mdio", 64'(bus.mdio_o), 64'd1);
        checkOutput("done_oe", 64'(bus.mdio_out_en), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
